bin_to_bcd_seq: RTL and testbench

//   Parametrised multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble),
//   one bit per clock. Generalises the 6-bit/2-digit combinational converter to any

---
 rtl/bin_to_bcd_seq.sv | 135 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// ready/valid handshakes, optional two's-complement input and overflow detection.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      valoare_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic                  overflow
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  operand_reg, operand_next;
    logic [BW-1:0]     acc_reg, acc_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              ovf_reg, ovf_next;
    logic              neg_reg, neg_next;
    logic [BW-1:0]     bcd_reg, bcd_next;
    logic              sign_reg, sign_next;
    logic              overflow_reg, overflow_next;

    logic [BW-1:0]     acc_adj;
    logic [BW-1:0]     acc_shift;
    logic              acc_carry;
    logic              in_neg;
    logic [WIDTH-1:0]  magnitude;

    // Add-3 correction per digit; digits never carry into each other.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                        acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
        end
    endgenerate

    assign acc_shift = {acc_adj[BW-2:0], operand_reg[WIDTH-1]};
    assign acc_carry = acc_adj[BW-1];

    generate
        if (SIGNED != 0) begin : g_signed
            assign in_neg = valoare_bin[WIDTH-1];
        end else begin : g_unsigned
            assign in_neg = 1'b0;
        end
    endgenerate

    // The most negative value negates to itself, which is the correct unsigned magnitude.
    assign magnitude = in_neg ? (~valoare_bin + WIDTH'(1)) : valoare_bin;

    always_comb begin
        state_next    = state_reg;
        operand_next  = operand_reg;
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
        ovf_next      = ovf_reg;
        neg_next      = neg_reg;
        bcd_next      = bcd_reg;
        sign_next     = sign_reg;
        overflow_next = overflow_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    operand_next = magnitude;
                    acc_next     = '0;
                    ovf_next     = 1'b0;
                    cnt_next     = '0;
                    neg_next     = in_neg;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                acc_next     = acc_shift;
                operand_next = {operand_reg[WIDTH-2:0], 1'b0};
                ovf_next     = ovf_reg | acc_carry;
                cnt_next     = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    // Published outputs change only here, so no partial result is visible.
                    bcd_next      = acc_shift;
                    overflow_next = ovf_reg | acc_carry;
                    sign_next     = neg_reg;
                    state_next    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            operand_reg  <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            neg_reg      <= 1'b0;
            bcd_reg      <= '0;
            sign_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            operand_reg  <= operand_next;
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            ovf_reg      <= ovf_next;
            neg_reg      <= neg_next;
            bcd_reg      <= bcd_next;
            sign_reg     <= sign_next;
            overflow_reg <= overflow_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign bcd       = bcd_reg;
    assign sign      = sign_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: four instances cover 16b/5d unsigned, 6b/2d,
// 16b/4d (overflow) and 16b/5d signed configurations.
module tb_bin_to_bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_a [4];
    logic        out_ready_a[4];
    logic [15:0] val_a      [4];
    wire         in_ready_a [4];
    wire         out_valid_a[4];
    wire         sign_a     [4];
    wire         ovf_a      [4];
    wire  [19:0] bcd_a      [4];
    logic [19:0] bcd0, bcd3;
    logic [7:0]  bcd1;
    logic [15:0] bcd2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) dut_u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .valoare_bin(val_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .bcd(bcd0), .sign(sign_a[0]), .overflow(ovf_a[0]));
    bin_to_bcd_seq #(.WIDTH(6), .DIGITS(2), .SIGNED(0)) dut_u6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .valoare_bin(val_a[1][5:0]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .bcd(bcd1), .sign(sign_a[1]), .overflow(ovf_a[1]));
    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4), .SIGNED(0)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .valoare_bin(val_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
        .bcd(bcd2), .sign(sign_a[2]), .overflow(ovf_a[2]));
    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) dut_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[3]), .in_ready(in_ready_a[3]),
        .valoare_bin(val_a[3]), .out_valid(out_valid_a[3]), .out_ready(out_ready_a[3]),
        .bcd(bcd3), .sign(sign_a[3]), .overflow(ovf_a[3]));

    assign bcd_a[0] = bcd0;
    assign bcd_a[1] = {12'h000, bcd1};
    assign bcd_a[2] = {4'h0, bcd2};
    assign bcd_a[3] = bcd3;

    // Present v for exactly one accepting edge; returns #1 after that edge.
    task automatic start_conv(input int d, input logic [15:0] v);
        @(negedge clk);
        val_a[d]      = v;
        in_valid_a[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a[d] = 1'b0;
    endtask

    // lat counts edges from the accepting edge (=1) until out_valid is seen; bounded.
    task automatic wait_done(input int d, output int lat);
        lat = 1;
        while (!out_valid_a[d] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack(input int d);
        @(negedge clk);
        out_ready_a[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a[d] = 1'b0;
    endtask

    task automatic convert(input int d, input logic [15:0] v,
                           output logic [19:0] b, output logic s, output logic o,
                           output int lat);
        start_conv(d, v);
        wait_done(d, lat);
        b = bcd_a[d];
        s = sign_a[d];
        o = ovf_a[d];
        ack(d);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if ({in_ready_a[d], out_valid_a[d], sign_a[d], ovf_a[d], bcd_a[d]} !== {1'b1, 1'b0, 1'b0, 1'b0, 20'h0}) begin
                miscompares++;
                $display("FAIL reset dut%0d: rdy=%b vld=%b sign=%b ovf=%b bcd=%h required rdy=1 vld=0 sign=0 ovf=0 bcd=00000",
                         d, in_ready_a[d], out_valid_a[d], sign_a[d], ovf_a[d], bcd_a[d]);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_unsigned16();
        logic [15:0] vin [4];
        logic [19:0] vexp[4];
        logic [19:0] b;
        logic s, o;
        int lat;
        vin  = '{16'd0, 16'd65535, 16'd1234, 16'd40960};
        vexp = '{20'h00000, 20'h65535, 20'h01234, 20'h40960};
        for (int i = 0; i < 4; i++) begin
            convert(0, vin[i], b, s, o, lat);
            vectors++;
            if ({b, s, o} !== {vexp[i], 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL u16 in=%0d: bcd=%h sign=%b ovf=%b required bcd=%h sign=0 ovf=0", vin[i], b, s, o, vexp[i]);
            end
            vectors++;
            if (lat !== 17) begin
                miscompares++;
                $display("FAIL u16_latency in=%0d: %0d edges, required 17", vin[i], lat);
            end
            $display("u16 in=%0d bcd=%h lat=%0d", vin[i], b, lat);
        end
    endtask

    task automatic test_sweep6();
        logic [19:0] b, e;
        logic s, o;
        int lat;
        for (int v = 0; v < 64; v++) begin
            e = 20'((v / 10) * 16 + (v % 10));
            convert(1, 16'(v), b, s, o, lat);
            vectors++;
            if ({b, o, lat} !== {e, 1'b0, 32'd7}) begin
                miscompares++;
                $display("FAIL sweep6 in=%0d: bcd=%h ovf=%b lat=%0d required bcd=%h ovf=0 lat=7", v, b, o, lat, e);
            end
        end
        $display("test_sweep6: 64 values converted");
    endtask

    task automatic test_overflow4();
        logic [15:0] vin [4];
        logic [19:0] vexp[4];
        logic        oexp[4];
        logic [19:0] b;
        logic s, o;
        int lat;
        vin  = '{16'd10000, 16'd9999, 16'd65535, 16'd12345};
        vexp = '{20'h00000, 20'h09999, 20'h05535, 20'h02345};
        oexp = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            convert(2, vin[i], b, s, o, lat);
            vectors++;
            if ({b, o} !== {vexp[i], oexp[i]}) begin
                miscompares++;
                $display("FAIL ovf4 in=%0d: bcd=%h ovf=%b required bcd=%h ovf=%b", vin[i], b, o, vexp[i], oexp[i]);
            end
            $display("ovf4 in=%0d bcd=%h ovf=%b", vin[i], b, o);
        end
    endtask

    task automatic test_signed();
        logic [15:0] vin [5];
        logic [19:0] vexp[5];
        logic        sexp[5];
        logic [19:0] b;
        logic s, o;
        int lat;
        vin  = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'hFF85, 16'h0000};
        vexp = '{20'h32768, 20'h00001, 20'h32767, 20'h00123, 20'h00000};
        sexp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            convert(3, vin[i], b, s, o, lat);
            vectors++;
            if ({b, s, o, lat} !== {vexp[i], sexp[i], 1'b0, 32'd17}) begin
                miscompares++;
                $display("FAIL signed in=%h: bcd=%h sign=%b ovf=%b lat=%0d required bcd=%h sign=%b ovf=0 lat=17",
                         vin[i], b, s, o, lat, vexp[i], sexp[i]);
            end
            $display("signed in=%h bcd=%h sign=%b", vin[i], b, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] b;
        logic s, o;
        int lat;
        convert(0, 16'd5, b, s, o, lat);
        vectors++;
        if ({out_valid_a[0], in_ready_a[0]} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_after_ack: vld=%b rdy=%b required vld=0 rdy=1", out_valid_a[0], in_ready_a[0]);
        end
        // Next accept lands on the very next edge after the acknowledging edge.
        convert(0, 16'd98, b, s, o, lat);
        vectors++;
        if ({b, lat} !== {20'h00098, 32'd17}) begin
            miscompares++;
            $display("FAIL b2b_second: bcd=%h lat=%0d required bcd=00098 lat=17", b, lat);
        end
        $display("b2b second bcd=%h lat=%0d", b, lat);
    endtask

    task automatic test_hold();
        int lat;
        start_conv(0, 16'd4321);
        wait_done(0, lat);
        vectors++;
        if (lat !== 17) begin
            miscompares++;
            $display("FAIL hold_latency: %0d edges, required 17", lat);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            in_valid_a[0] = (i % 3 == 0);
            val_a[0]      = 16'd7777;
            @(posedge clk);
            #1;
            vectors++;
            if ({out_valid_a[0], in_ready_a[0], ovf_a[0], bcd_a[0]} !== {1'b1, 1'b0, 1'b0, 20'h04321}) begin
                miscompares++;
                $display("FAIL hold cycle %0d: vld=%b rdy=%b ovf=%b bcd=%h required vld=1 rdy=0 ovf=0 bcd=04321",
                         i, out_valid_a[0], in_ready_a[0], ovf_a[0], bcd_a[0]);
            end
        end
        in_valid_a[0] = 1'b0;
        ack(0);
        vectors++;
        if ({out_valid_a[0], in_ready_a[0], bcd_a[0]} !== {1'b0, 1'b1, 20'h04321}) begin
            miscompares++;
            $display("FAIL hold_release: vld=%b rdy=%b bcd=%h required vld=0 rdy=1 bcd=04321",
                     out_valid_a[0], in_ready_a[0], bcd_a[0]);
        end
        $display("hold: 50 cycles held bcd=%h", bcd_a[0]);
    endtask

    task automatic test_reset_mid();
        logic [19:0] b;
        logic s, o;
        int lat;
        start_conv(0, 16'd999);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid_a[0], sign_a[0], ovf_a[0], bcd_a[0]} !== {1'b0, 1'b0, 1'b0, 20'h0}) begin
            miscompares++;
            $display("FAIL reset_mid: vld=%b sign=%b ovf=%b bcd=%h required all 0",
                     out_valid_a[0], sign_a[0], ovf_a[0], bcd_a[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({in_ready_a[0], out_valid_a[0]} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_mid_idle: rdy=%b vld=%b required rdy=1 vld=0", in_ready_a[0], out_valid_a[0]);
        end
        convert(0, 16'd8642, b, s, o, lat);
        vectors++;
        if ({b, o, lat} !== {20'h08642, 1'b0, 32'd17}) begin
            miscompares++;
            $display("FAIL reset_mid_next: bcd=%h ovf=%b lat=%0d required bcd=08642 ovf=0 lat=17", b, o, lat);
        end
        $display("reset_mid: next conversion bcd=%h", b);
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            in_valid_a[d]  = 1'b0;
            out_ready_a[d] = 1'b0;
            val_a[d]       = 16'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_unsigned16();
        test_sweep6();
        test_overflow4();
        test_signed();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
